aes_mixcol_seq: RTL and testbench

- Sequential full-state MixColumns / InvMixColumns engine for the AES datapath.
- Takes a 128-bit AES state over a valid/ready handshake and latches the direction per block.
- Transforms COLS_PER_CYCLE columns per clock through replicated column mixers.
- Returns the 128-bit result over a second valid/ready handshake, so the round controller can time-share one mixer between the encrypt and decrypt paths.

---
 rtl/aes_mixcol_seq.sv | 153 +++++++++++++++
 tb/tb_aes_mixcol_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_mixcol_seq.sv
// aes_mixcol_seq: sequential full-state AES MixColumns / InvMixColumns engine.
//
// A 128-bit state is accepted over a valid/ready handshake together with its
// direction bit. COLS_PER_CYCLE column mixers then transform the state in place,
// a slice of columns per cycle. The result is offered over a second
// valid/ready handshake.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   input block offered
//   in_ready   engine can accept a block (IDLE)
//   in_E_D     direction, sampled on accept: 0 = MixColumns, 1 = InvMixColumns
//   in_state   AES state; column c = bits [127-32c : 96-32c], byte 0 is the MSB
//   out_valid  result block available (DONE)
//   out_ready  consumer accepts result
//   out_state  transformed state, same layout as in_state
//   busy       engine is in BUSY or DONE
module aes_mixcol_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_E_D,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gen_bad_cols
    $error("aes_mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e         state_q;
  logic [1:0]     cnt_q;
  logic [127:0]   work_q, work_d;
  logic           mode_q;
  logic           in_ready_q, out_valid_q, busy_q;
  logic           cnt_last;
  logic [1:0]     col_idx, col_sel;

  // GF(2^8) multiply by 2, reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One column mixer; all multiples come from a shared xtime chain per byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x3 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] x9 [4];
    logic [7:0] xb [4];
    logic [7:0] xd [4];
    logic [7:0] xe [4];
    logic [7:0] b  [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      x3[i] = x2[i] ^ a[i];
      x9[i] = x8[i] ^ a[i];
      xb[i] = x8[i] ^ x2[i] ^ a[i];
      xd[i] = x8[i] ^ x4[i] ^ a[i];
      xe[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    // Row r is the circulant row rotated right by r.
    for (int r = 0; r < 4; r++) begin
      if (inv) begin
        b[r] = xe[r] ^ xb[(r+1)%4] ^ xd[(r+2)%4] ^ x9[(r+3)%4];
      end else begin
        b[r] = x2[r] ^ x3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  assign cnt_last = ({1'b0, cnt_q} + 3'(COLS_PER_CYCLE)) == 3'd4;

  // Replicated mixers: columns cnt..cnt+COLS_PER_CYCLE-1 are rewritten in place.
  always_comb begin
    work_d  = work_q;
    col_idx = '0;
    col_sel = '0;
    for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
      col_idx = cnt_q + 2'(g);
      col_sel = 2'd3 - col_idx;
      work_d[{col_sel, 5'd0} +: 32] = mix_column(work_q[{col_sel, 5'd0} +: 32], mode_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      work_q      <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            work_q     <= in_state;
            mode_q     <= in_E_D;
            cnt_q      <= '0;
            state_q    <= StBusy;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StBusy: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 2'(COLS_PER_CYCLE);
          if (cnt_last) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Bench for aes_mixcol_seq: three instances (1, 2 and 4 columns per cycle) are
// driven with directed vectors and random blocks checked against a generic
// GF(2^8) multiply reference.
module tb_aes_mixcol_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_a  [3];
  logic         in_ready_a  [3];
  logic         in_e_d_a    [3];
  logic [127:0] in_state_a  [3];
  logic         out_valid_a [3];
  logic         out_ready_a [3];
  logic [127:0] out_state_a [3];
  logic         busy_a      [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_mixcol_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_E_D(in_e_d_a[0]), .in_state(in_state_a[0]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready_a[0]), .out_state(out_state_a[0]), .busy(busy_a[0])
  );
  aes_mixcol_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_E_D(in_e_d_a[1]), .in_state(in_state_a[1]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready_a[1]), .out_state(out_state_a[1]), .busy(busy_a[1])
  );
  aes_mixcol_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .in_E_D(in_e_d_a[2]), .in_state(in_state_a[2]), .out_valid(out_valid_a[2]),
    .out_ready(out_ready_a[2]), .out_state(out_state_a[2]), .busy(busy_a[2])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int cpc(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  // Plain shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] st, input logic inv);
    logic [7:0]   cf [4];
    logic [7:0]   a  [4];
    logic [7:0]   b;
    logic [127:0] res;
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = st[127-32*c-8*j -: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(a[j], cf[(j-r+4)%4]);
        res[127-32*c-8*r -: 8] = b;
      end
    end
    return res;
  endfunction

  // Offer one block to instance d, scramble inputs while it runs, hold
  // out_ready low for 'hold' cycles once the result appears, then take it.
  task automatic run_block(input int d, input logic [127:0] st, input logic ed,
                           input int hold, output logic [127:0] res);
    int k;
    res = '0;
    @(negedge clk);
    in_state_a[d] = st;
    in_e_d_a[d]   = ed;
    in_valid_a[d] = 1'b1;
    k = 0;
    while (!in_ready_a[d] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready_a[d]) begin
      check("accept_timeout", 128'(in_ready_a[d]), 128'(1));
      in_valid_a[d] = 1'b0;
      return;
    end
    @(posedge clk);  // accept edge
    #1;
    in_valid_a[d] = 1'b0;
    in_state_a[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_e_d_a[d]   = ~ed;
    k = 0;
    @(negedge clk);
    while (!out_valid_a[d] && k < 20) begin
      in_state_a[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_e_d_a[d]   = ~in_e_d_a[d];
      @(negedge clk);
      k++;
    end
    // k edges after the accept edge; the accept edge itself counts as the first.
    check("latency", 128'(k + 1), 128'(4 / cpc(d) + 1));
    if (!out_valid_a[d]) return;
    res = out_state_a[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("bp_state", out_state_a[d], res);
      check("bp_flags", 128'({out_valid_a[d], in_ready_a[d], busy_a[d]}), 128'(3'b101));
    end
    out_ready_a[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a[d] = 1'b0;
    @(negedge clk);
    check("release", 128'({out_valid_a[d], in_ready_a[d], busy_a[d]}), 128'(3'b010));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, st, mixed_in, mixed_out;
    logic         ed;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid_a[d] = 1'b0; in_e_d_a[d] = 1'b0; in_state_a[d] = '0; out_ready_a[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_flags", 128'({out_valid_a[d], in_ready_a[d], busy_a[d]}), 128'(3'b010));
      check("reset_state", out_state_a[d], '0);
    end
    rst = 1'b0;

    mixed_in  = 128'hd4d4d4d5_2d26314c_f20a225c_c6c6c6c6;
    mixed_out = 128'hd5d5d7d6_4d7ebdf8_9fdc589d_c6c6c6c6;

    for (int d = 0; d < 3; d++) begin
      run_block(d, {4{32'hdb135345}}, 1'b0, 0, res);
      check("fwd_db135345", res, {4{32'h8e4da1bc}});
      run_block(d, mixed_in, 1'b0, 0, res);
      check("fwd_mixed", res, mixed_out);
      run_block(d, mixed_out, 1'b1, 0, res);
      check("inv_mixed", res, mixed_in);
      run_block(d, {4{32'h01010101}}, 1'b0, 0, res);
      check("fwd_01", res, {4{32'h01010101}});
      run_block(d, {4{32'h01010101}}, 1'b1, 0, res);
      check("inv_01", res, {4{32'h01010101}});
    end

    // Backpressure on the default instance.
    run_block(0, mixed_in, 1'b0, 10, res);
    check("bp_result", res, mixed_out);

    // Reset in the second BUSY cycle discards the block.
    @(negedge clk);
    in_state_a[0] = mixed_in; in_e_d_a[0] = 1'b0; in_valid_a[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_a[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_flags", 128'({out_valid_a[0], in_ready_a[0], busy_a[0]}), 128'(3'b010));
    check("rst_mid_state", out_state_a[0], '0);
    repeat (6) @(negedge clk);
    check("rst_mid_no_out", 128'(out_valid_a[0]), 128'(0));
    run_block(0, {4{32'hdb135345}}, 1'b0, 0, res);
    check("after_rst", res, {4{32'h8e4da1bc}});

    for (int i = 0; i < 1000; i++) begin
      st = {$urandom(), $urandom(), $urandom(), $urandom()};
      ed = 1'(i & 1);
      run_block(i % 3, st, ed, 0, res);
      check("random", res, ref_mix(st, ed));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
